countdown_ctrl: RTL

Run/pause/alarm controller that sits directly upstream of the 30-minute MM:SS countdown chain and its 7-segment display path. It debounces the raw start/clear buttons and drives the countdown's enable and clear inputs. It consumes the countdown's terminal "00:00" flag and then sounds a timed buzzer alarm. It also drives a blink/blank request to the display scan logic while paused or alarming.

---
 rtl/countdown_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: run/pause/alarm controller sitting ahead of the MM:SS countdown chain
//
// Debounces the raw start/clear buttons, drives the countdown enable/reload,
// sounds a timed buzzer alarm once the countdown reaches 00:00 and requests
// display blinking while paused or alarming.
//
// Ports:
//   clk_in       system clock, rising edge
//   reset        asynchronous active-high reset
//   btn_start_i  raw start/pause button (bouncy, asynchronous)
//   btn_clear_i  raw clear button (bouncy, asynchronous)
//   tick_1s_i    one-cycle pulse per second
//   zero_in_i    countdown shows 00:00
//   run_en_o     countdown enable, high only in RUN
//   cnt_clear_o  one-cycle countdown reload pulse
//   state_o      00 IDLE, 01 RUN, 10 PAUSE, 11 ALARM
//   buzzer_o     square-wave tone during ALARM
//   blink_o      display blank request, toggles per second in PAUSE/ALARM
module countdown_ctrl #(
   parameter int DEB_CNT   = 200000,
   parameter int DEB_W     = 18,
   parameter int TONE_DIV  = 5000,
   parameter int TONE_W    = 13,
   parameter int ALARM_SEC = 10
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       btn_start_i,
   input  logic       btn_clear_i,
   input  logic       tick_1s_i,
   input  logic       zero_in_i,
   output logic       run_en_o,
   output logic       cnt_clear_o,
   output logic [1:0] state_o,
   output logic       buzzer_o,
   output logic       blink_o
);
   localparam int ALM_W = $clog2(ALARM_SEC + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      ALARM = 2'b11
   } state_t;

   // bit 0 = start, bit 1 = clear
   logic [1:0]       btn_raw;
   logic [1:0]       sync1_q, sync2_q, deb_q, deb_dly_q;
   logic [DEB_W-1:0] deb_cnt_q [2];
   logic [1:0]       press;

   state_t            state_q, state_d;
   logic              clr_d, cnt_clear_q, run_en_q;
   logic [ALM_W-1:0]  alm_q, alm_d;
   logic [TONE_W-1:0] tone_q, tone_d;
   logic              buzz_q, buzz_d, blink_q, blink_d;
   logic              stay, in_alarm, tone_wrap, alm_done;

   assign btn_raw = {btn_clear_i, btn_start_i};
   assign press   = deb_q & ~deb_dly_q;

   // The debounced level only follows the synchronized input once it has
   // disagreed for DEB_CNT consecutive cycles; any agreement restarts the count.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         deb_q     <= '0;
         deb_dly_q <= '0;
         for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
      end else begin
         sync1_q   <= btn_raw;
         sync2_q   <= sync1_q;
         deb_dly_q <= deb_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
               deb_cnt_q[i] <= '0;
            end else if (deb_cnt_q[i] == DEB_W'(DEB_CNT - 1)) begin
               deb_q[i]     <= sync2_q[i];
               deb_cnt_q[i] <= '0;
            end else begin
               deb_cnt_q[i] <= deb_cnt_q[i] + DEB_W'(1);
            end
         end
      end
   end

   assign alm_done = tick_1s_i && (alm_q == ALM_W'(ALARM_SEC - 1));

   // Clear beats everything; in RUN the terminal flag beats a start press so
   // the countdown is stopped before it could wrap past 00:00.
   always_comb begin
      state_d = state_q;
      clr_d   = 1'b0;
      if (press[1]) begin
         state_d = IDLE;
         clr_d   = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (press[0]) begin
                  state_d = RUN;
                  clr_d   = zero_in_i;
               end
            end
            RUN: begin
               if (zero_in_i) state_d = ALARM;
               else if (press[0]) state_d = PAUSE;
            end
            PAUSE: begin
               if (press[0]) state_d = RUN;
            end
            ALARM: begin
               if (press[0] || alm_done) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Per-state counters only advance while the state is held; any transition
   // (including entry) returns them to zero, so an entry-cycle tick is dropped.
   assign stay      = (state_d == state_q);
   assign in_alarm  = stay && (state_q == ALARM);
   assign tone_wrap = (tone_q == TONE_W'(TONE_DIV - 1));
   assign alm_d     = in_alarm ? alm_q + ALM_W'(tick_1s_i) : '0;
   assign tone_d    = (in_alarm && !tone_wrap) ? tone_q + TONE_W'(1) : '0;
   assign buzz_d    = in_alarm && (buzz_q ^ tone_wrap);
   assign blink_d   = stay && (state_q == PAUSE || state_q == ALARM) && (blink_q ^ tick_1s_i);

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         run_en_q    <= 1'b0;
         cnt_clear_q <= 1'b0;
         alm_q       <= '0;
         tone_q      <= '0;
         buzz_q      <= 1'b0;
         blink_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_en_q    <= (state_d == RUN);
         cnt_clear_q <= clr_d;
         alm_q       <= alm_d;
         tone_q      <= tone_d;
         buzz_q      <= buzz_d;
         blink_q     <= blink_d;
      end
   end

   assign state_o     = state_q;
   assign run_en_o    = run_en_q;
   assign cnt_clear_o = cnt_clear_q;
   assign buzzer_o    = buzz_q;
   assign blink_o     = blink_q;
endmodule
